// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: control/ALU decode, immediates, 32x32 register file, ID/EX register.
// Define DECODE_REGFILE_BYPASS_EN to forward a same-edge writeback onto the read ports.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idex_t;

    idex_t       idex_d, idex_q;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  imm_src;
    logic [1:0]  alu_op;
    logic [31:0] regs_q [32];
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rd1, rd2;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    always_comb begin
        idex_d            = '0;
        imm_src           = IMM_I;
        alu_op            = 2'b00;
        case (opcode)
            OP_LW: begin
                idex_d.reg_write  = 1'b1;
                idex_d.alu_src    = 1'b1;
                idex_d.result_src = 2'b01;
            end
            OP_SW: begin
                idex_d.mem_write  = 1'b1;
                idex_d.alu_src    = 1'b1;
                imm_src           = IMM_S;
            end
            OP_R: begin
                idex_d.reg_write  = 1'b1;
                alu_op            = 2'b10;
            end
            OP_I: begin
                idex_d.reg_write  = 1'b1;
                idex_d.alu_src    = 1'b1;
                alu_op            = 2'b10;
            end
            OP_BEQ: begin
                idex_d.branch     = 1'b1;
                imm_src           = IMM_B;
                alu_op            = 2'b01;
            end
            OP_JAL: begin
                idex_d.reg_write  = 1'b1;
                idex_d.jump       = 1'b1;
                idex_d.result_src = 2'b10;
                imm_src           = IMM_J;
            end
            default: ;
        endcase

        // funct7[5] selects sub only for R-type; I-type uses that bit as immediate.
        case (alu_op)
            2'b01:   idex_d.alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  idex_d.alu_control = (opcode[5] & InstrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  idex_d.alu_control = 3'b101;
                    3'b110:  idex_d.alu_control = 3'b011;
                    3'b111:  idex_d.alu_control = 3'b010;
                    default: idex_d.alu_control = 3'b000;
                endcase
            end
            default: idex_d.alu_control = 3'b000;
        endcase

        case (imm_src)
            IMM_S:   idex_d.imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   idex_d.imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   idex_d.imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: idex_d.imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        endcase

        idex_d.rd1      = rd1;
        idex_d.rd2      = rd2;
        idex_d.pc       = PCD;
        idex_d.pc_plus4 = PCPlus4D;
        idex_d.rd       = InstrD[11:7];
        idex_d.rs1      = Rs1D;
        idex_d.rs2      = Rs2D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (RegWriteW && (RDW != 5'd0)) begin
            regs_q[RDW] <= ResultW;
        end
    end

    assign rf_rd1 = (Rs1D == 5'd0) ? 32'd0 : regs_q[Rs1D];
    assign rf_rd2 = (Rs2D == 5'd0) ? 32'd0 : regs_q[Rs2D];

`ifdef DECODE_REGFILE_BYPASS_EN
    assign rd1 = (RegWriteW && (RDW != 5'd0) && (RDW == Rs1D)) ? ResultW : rf_rd1;
    assign rd2 = (RegWriteW && (RDW != 5'd0) && (RDW == Rs2D)) ? ResultW : rf_rd2;
`else
    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign ResultSrcE  = idex_q.result_src;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUControlE = idex_q.alu_control;
    assign ALUSrcE     = idex_q.alu_src;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm_ext;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign RdE         = idex_q.rd;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. It consumes the IF/ID outputs (`InstrD`, `PCD`, `PCPlus4D`) and holds the 32×32 integer register file, with its write port driven from writeback. It also decodes control signals and extends immediates. All results are captured in the ID/EX pipeline register, which feeds the execute stage.

## Interface
- no parameters; widths fixed (XLEN 32, 32 architectural registers)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `InstrD`  in  32  instruction from IF/ID
- `PCD`  in  32  PC of `InstrD`
- `PCPlus4D`  in  32  `PCD`+4
- `RegWriteW`  in  1  writeback enable
- `RDW`  in  5  writeback destination register
- `ResultW`  in  32  writeback data
- `FlushE`  in  1  synchronous bubble insert into ID/EX
- `Rs1D`, `Rs2D`  out  5 each  combinational `InstrD[19:15]` and `InstrD[24:20]`, for the hazard unit
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`  out  1 each  registered controls
- `ResultSrcE`  out  2  00 = ALU, 01 = memory, 10 = PC+4
- `ALUControlE`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E`  out  32 each
- `RdE`, `Rs1E`, `Rs2E`  out  5 each

## Operation
- **Opcode decode** (`InstrD[6:0]`):
  - lw 0000011: RegWrite, ALUSrc, ResultSrc = 01, ImmSrc I, ALUOp 00
  - sw 0100011: MemWrite, ALUSrc, ImmSrc S, ALUOp 00
  - R-type 0110011: RegWrite, ALUOp 10
  - I-ALU 0010011: RegWrite, ALUSrc, ImmSrc I, ALUOp 10
  - beq 1100011: Branch, ImmSrc B, ALUOp 01
  - jal 1101111: RegWrite, Jump, ResultSrc = 10, ImmSrc J
  - any other opcode: all controls 0 (NOP)
- **ALU decode**:
  - ALUOp 00 → add; ALUOp 01 → sub
  - ALUOp 10, by funct3:
    - 000: sub only if `op[5] & funct7[5]`, else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add
- **Immediate extension** (all sign-extended from `InstrD[31]`):
  - I = `[31:20]`
  - S = `{[31:25],[11:7]}`
  - B = `{[31],[7],[30:25],[11:8],0}`
  - J = `{[31],[19:12],[20],[30:21],0}`
- **Register file**:
  - Two combinational read ports addressed by `Rs1D`/`Rs2D`; one write port.
  - Write occurs on rising `clk` when `RegWriteW=1` and `RDW≠0`.
  - x0 always reads 0 and is never written.
  - All 32 entries clear to 0 on reset.
- **ID/EX register**: captures every `*E` output from its `*D` counterpart each rising edge.
  - `FlushE=1` loads all zeros (bubble), overriding new data.
  - `FlushE` has no effect on register-file writes.

## Timing
- Latency: `InstrD` at cycle N appears decoded on the `*E` outputs after edge N+1 (one cycle).
- `Rs1D`/`Rs2D` are zero-latency combinational outputs.
- `rst` low, at any time including mid-stream:
  - All `*E` outputs go to 0 immediately (asynchronously).
  - The register file clears to 0.
  - An in-flight writeback that cycle is lost.
- `rst` release is synchronous in effect: the first capture happens on the first rising edge with `rst=1`.
- Same-edge write to register r and read of r by `InstrD`: behaviour is set by the macro (see Configuration).
- Simultaneous `FlushE` and writeback: the write commits; the ID/EX register still zeros.

## Configuration
- `DECODE_REGFILE_BYPASS_EN` defined:
  - A read port whose address equals `RDW`, with `RegWriteW=1` and `RDW≠0`, returns `ResultW` combinationally.
  - The ID/EX register therefore captures the new value on the same edge as the write.
- Not defined:
  - Reads return array contents only, so the ID/EX register captures the old value on that edge.
  - The hazard unit must stall or forward for this case.

## Test plan
- **Reset:** preload x1 = 5, drive `rst=0` mid-stream → all `*E` outputs 0 immediately; after release, reading x1 returns 0.
- **R-type:** preload x1 = 5, x2 = 7; `InstrD`=0x002081B3 (add x3,x1,x2) → next edge `RD1E`=5, `RD2E`=7, `RdE`=3, `RegWriteE`=1, `ALUSrcE`=0, `ALUControlE`=000, `ResultSrcE`=00.
- **Load:** `InstrD`=0xFFC12283 (lw x5,-4(x2)) → `ImmExtE`=0xFFFFFFFC, `ALUSrcE`=1, `ResultSrcE`=01, `RdE`=5, `MemWriteE`=0.
- **Branch:** `InstrD`=0xFE208CE3 (beq x1,x2,-8) → `ImmExtE`=0xFFFFFFF8, `BranchE`=1, `ALUControlE`=001, `RegWriteE`=0.
- **x0 and flush:** write `RDW`=0, `ResultW`=0xDEADBEEF → reading x0 gives 0. Then `FlushE`=1 with a valid add → all `*E` outputs 0 after the edge.
- **Same-cycle write/read:** `RegWriteW`=1, `RDW`=1, `ResultW`=0x12345678, while x1 holds 5, in the same cycle as `InstrD` reads x1 → `RD1E`=0x12345678 with the macro, 5 without it; the array holds 0x12345678 in both builds.
